pixel_readout: RTL and testbench
================================

# pixel_readout

Readout sequencer that sits directly downstream of the exposure controller in the digital camera. While the controller holds ADC high and drives one row-enable (NRE_1 or NRE_2) low, this block steps through that row's columns: it starts the shared column ADC, captures each conversion result, and hands it to the frame buffer over a valid/ready handshake with a linear pixel address. It flags frame completion and readout errors (window closed early, conversion timeout).

## Interface
Parameters:
- DATA_W, 8, ADC sample width
- COLS, 2, columns per row; 2 rows fixed (NRE_1, NRE_2)
- CONV_TIMEOUT, 64, max cycles from Adc_start to Adc_done

Ports:
- Clk  in  1  single system clock, rising edge
- Reset  in  1  asynchronous, active-low reset
- ADC  in  1  readout window from exposure controller, active-high
- NRE_1  in  1  row 1 enable, active-low
- NRE_2  in  1  row 2 enable, active-low
- Adc_start  out  1  one-cycle conversion start pulse
- Col_sel  out  clog2(COLS)  column mux select, stable from Adc_start until Adc_done
- Adc_done  in  1  conversion complete, one-cycle pulse
- Adc_data  in  DATA_W  sample, valid on the Adc_done cycle
- Pix_data  out  DATA_W  captured sample
- Pix_addr  out  clog2(2*COLS)  row*COLS + col, row 0 = NRE_1
- Pix_valid  out  1  pixel available to frame buffer
- Pix_ready  in  1  frame buffer accepts
- Frame_done  out  1  one-cycle pulse after last pixel of row 2 accepted
- Overrun  out  1  sticky: window closed before row fully read
- Timeout  out  1  sticky: Adc_done missing for CONV_TIMEOUT cycles

## Operation
- States: IDLE, START, CONV, OUT, ROW_WAIT.
- IDLE: row request = ADC & (~NRE_1 | ~NRE_2). NRE_1 has priority if both are low. On request: latch row, col=0, go to START. A request for row 0 clears Overrun and Timeout.
- START: Adc_start=1 for exactly one cycle, Col_sel=col, timeout counter cleared; go to CONV.
- CONV: wait for Adc_done. On Adc_done: Pix_data<=Adc_data, Pix_addr<=row*COLS+col, go to OUT. The counter reaching CONV_TIMEOUT sets Timeout and goes to ROW_WAIT.
- OUT: Pix_valid=1. On Pix_valid&Pix_ready: if col<COLS-1 then col+1, go to START. Otherwise go to ROW_WAIT, and pulse Frame_done if row=1.
- ROW_WAIT: wait until the latched row's NRE is high or ADC is low, then go to IDLE. This prevents re-reading the same row.
- Window abort: in START, CONV or OUT, if ADC goes low or the latched row's NRE goes high:
  - Set Overrun.
  - Drop Pix_valid with no transfer.
  - Ignore any pending Adc_done.
  - Go to IDLE.
- Remaining pixels of an aborted row are not emitted. Frame_done does not fire for an aborted frame.
- Row 2 may be read without row 1 having been read; its addresses are still COLS..2*COLS-1.

## Timing
- Reset (async assert, sync release): state IDLE, col 0, all outputs 0 (Adc_start, Col_sel, Pix_data, Pix_addr, Pix_valid, Frame_done, Overrun, Timeout).
- Request sampled at edge N: Adc_start high in cycle N+1.
- Adc_done at edge M: Pix_valid high from cycle M+1.
- Pix_data and Pix_addr are stable while Pix_valid & ~Pix_ready.
- Transfer at edge T (valid & ready): next Adc_start in cycle T+1, or ROW_WAIT.
- Zero-stall throughput per pixel: 1 (START) + conversion latency + 1 (OUT) cycles.
- Frame_done is high in cycle T+1 after the final transfer.
- Adc_done outside CONV is ignored.
- Reset mid-readout clears everything immediately. No pixel emission resumes until a fresh request.
- Overrun and Timeout hold until the next row-0 request or Reset.

## Test plan
- Full frame, COLS=2, ADC converts in 4 cycles, Pix_ready tied 1, samples 0x11,0x22,0x33,0x44 -> 4 transfers with addr 0,1,2,3 and those data; Frame_done one pulse; no flags.
- Backpressure: Pix_ready low for 5 cycles on addr 1 -> Pix_valid held, data/addr stable; no Adc_start until accepted; data order intact.
- Early abort: NRE_1 rises while addr 1 is in CONV -> Overrun=1, no addr 1 output; row 2 still emits addr 2,3; no Frame_done.
- Timeout: Adc_done never asserted -> Timeout=1 after 64 cycles, state ROW_WAIT; next row-0 request clears it.
- Priority and hold: NRE_1 and NRE_2 low together -> row 0 read once only; while NRE_1 stays low after completion, no second readout.
- Async reset asserted mid-OUT (Pix_valid=1) -> all outputs 0 immediately, IDLE after release.

Source files
------------

// File: rtl/pixel_readout.sv
// pixel_readout: steps the shared column ADC across the enabled row and hands
// each sample to the frame buffer with its linear pixel address.
module pixel_readout #(
    parameter int DATA_W = 8,
    parameter int COLS = 2,
    parameter int CONV_TIMEOUT = 64,
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1,
    localparam int AW = $clog2(2 * COLS),
    localparam int TW = $clog2(CONV_TIMEOUT + 1)
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              ADC,
    input  logic              NRE_1,
    input  logic              NRE_2,
    output logic              Adc_start,
    output logic [CW-1:0]     Col_sel,
    input  logic              Adc_done,
    input  logic [DATA_W-1:0] Adc_data,
    output logic [DATA_W-1:0] Pix_data,
    output logic [AW-1:0]     Pix_addr,
    output logic              Pix_valid,
    input  logic              Pix_ready,
    output logic              Frame_done,
    output logic              Overrun,
    output logic              Timeout
);
    localparam logic [2:0] IDLE = 3'd0, START = 3'd1, CONV = 3'd2, OUT = 3'd3, ROW_WAIT = 3'd4;
    localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);
    localparam logic [TW-1:0] LAST_CNT = TW'(CONV_TIMEOUT - 1);
    logic [2:0]    state;
    logic          row;
    logic [CW-1:0] col;
    logic [TW-1:0] cnt;
    logic          req, closed, busy;
    assign req = ADC & (~NRE_1 | ~NRE_2);
    // The latched row's window: closed when ADC drops or its enable deasserts.
    assign closed = ~ADC | (row ? NRE_2 : NRE_1);
    assign busy = (state == START) | (state == CONV) | (state == OUT);
    assign Adc_start = (state == START) & ~closed;
    assign Pix_valid = (state == OUT) & ~closed;
    assign Col_sel = col;
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state      <= IDLE;
            row        <= 1'b0;
            col        <= '0;
            cnt        <= '0;
            Pix_data   <= '0;
            Pix_addr   <= '0;
            Frame_done <= 1'b0;
            Overrun    <= 1'b0;
            Timeout    <= 1'b0;
        end else begin
            Frame_done <= 1'b0;
            if (busy && closed) begin
                Overrun <= 1'b1;
                state   <= IDLE;
            end else begin
                case (state)
                    IDLE: if (req) begin
                        row   <= NRE_1;
                        col   <= '0;
                        state <= START;
                        if (!NRE_1) begin
                            Overrun <= 1'b0;
                            Timeout <= 1'b0;
                        end
                    end
                    START: begin
                        cnt   <= '0;
                        state <= CONV;
                    end
                    CONV: if (Adc_done) begin
                        Pix_data <= Adc_data;
                        Pix_addr <= row ? AW'(COLS) + AW'(col) : AW'(col);
                        state    <= OUT;
                    end else if (cnt == LAST_CNT) begin
                        Timeout <= 1'b1;
                        state   <= ROW_WAIT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                    OUT: if (Pix_ready) begin
                        if (col == LAST_COL) begin
                            state      <= ROW_WAIT;
                            // A frame that saw an abort never reports completion.
                            Frame_done <= row & ~Overrun;
                        end else begin
                            col   <= col + 1'b1;
                            state <= START;
                        end
                    end
                    ROW_WAIT: if (closed) state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_pixel_readout.sv
// tb_pixel_readout: randomized readout scenarios checked against a transfer-list model.
module tb_pixel_readout;
    localparam int CONV_TIMEOUT = 64;
    logic       Clk = 0, Reset = 0, ADC = 0, NRE_1 = 1, NRE_2 = 1;
    logic       Adc_done = 0, Pix_ready = 0;
    logic [7:0] Adc_data = '0;
    logic       Adc_start, Pix_valid, Frame_done, Overrun, Timeout;
    logic [0:0] Col_sel;
    logic [1:0] Pix_addr;
    logic [7:0] Pix_data;
    int n_cmp = 0, n_err = 0, cyc = 0, lat = 4;
    int fd_cnt = 0, fd_cyc = 0, last_xfer_cyc = 0;
    bit adc_en = 1, busy = 0, rnd_ready = 0;
    logic [7:0] adc_vals[$], sent[$], got_data[$];
    logic [1:0] got_addr[$];
    logic [0:0] sel_q[$];
    int start_cyc[$];

    pixel_readout #(.DATA_W(8), .COLS(2), .CONV_TIMEOUT(CONV_TIMEOUT)) dut (
        .Clk(Clk), .Reset(Reset), .ADC(ADC), .NRE_1(NRE_1), .NRE_2(NRE_2),
        .Adc_start(Adc_start), .Col_sel(Col_sel), .Adc_done(Adc_done),
        .Adc_data(Adc_data), .Pix_data(Pix_data), .Pix_addr(Pix_addr),
        .Pix_valid(Pix_valid), .Pix_ready(Pix_ready), .Frame_done(Frame_done),
        .Overrun(Overrun), .Timeout(Timeout)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc = cyc + 1;
    always @(posedge Clk) begin
        #1;
        if (rnd_ready) Pix_ready = 1'($urandom_range(0, 1));
    end

    // Observe what the coming edge will commit.
    always @(negedge Clk) if (Reset) begin
        if (Pix_valid && Pix_ready) begin
            got_addr.push_back(Pix_addr);
            got_data.push_back(Pix_data);
            last_xfer_cyc = cyc;
        end
        if (Frame_done) begin
            fd_cnt = fd_cnt + 1;
            fd_cyc = cyc;
        end
        if (Adc_start) start_cyc.push_back(cyc);
    end

    // Column ADC: answers each start after lat cycles.
    initial forever begin
        @(negedge Clk);
        if (Reset && Adc_start && adc_en) begin
            busy = 1;
            sel_q.push_back(Col_sel);
            @(posedge Clk);
            repeat (lat - 1) @(posedge Clk);
            #1;
            Adc_done = 1;
            Adc_data = (adc_vals.size() > 0) ? adc_vals.pop_front() : 8'($urandom);
            sent.push_back(Adc_data);
            @(posedge Clk);
            #1;
            Adc_done = 0;
            busy = 0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic wait_got(input int n);
        for (int t = 0; t < 400 && got_addr.size() < n; t++) tick();
    endtask

    task automatic idle_all();
        ADC = 0; NRE_1 = 1; NRE_2 = 1; rnd_ready = 0; adc_en = 1;
        tick(2);
        Pix_ready = 0;
        for (int t = 0; t < 200 && busy; t++) tick();
        tick(3);
        got_addr.delete(); got_data.delete(); sent.delete();
        start_cyc.delete(); sel_q.delete(); adc_vals.delete();
        fd_cnt = 0;
    endtask

    task automatic test_reset();
        tick(3);
        n_cmp++;
        if ({Adc_start, Col_sel, Pix_data, Pix_addr, Pix_valid, Frame_done, Overrun, Timeout} !== '0) begin
            n_err++; $display("FAIL reset_outputs: got nonzero output, required all 0");
        end
        Reset = 1;
        tick(3);
        n_cmp++;
        if ({Adc_start, Pix_valid, Overrun, Timeout} !== 4'b0) begin
            n_err++; $display("FAIL reset_release: got %b, required 0000", {Adc_start, Pix_valid, Overrun, Timeout});
        end
    endtask

    task automatic test_full_frame();
        logic [7:0] tbl[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        int req_cyc;
        idle_all();
        lat = 4;
        foreach (tbl[i]) adc_vals.push_back(tbl[i]);
        Pix_ready = 1; ADC = 1; NRE_1 = 0; req_cyc = cyc;
        wait_got(2);
        NRE_1 = 1;
        tick(2);
        NRE_2 = 0;
        wait_got(4);
        tick(3);
        n_cmp++;
        if (got_addr.size() != 4) begin
            n_err++; $display("FAIL full_count: got %0d transfers, required 4", got_addr.size());
        end
        for (int i = 0; i < 4 && i < got_addr.size(); i++) begin
            n_cmp++;
            if (got_addr[i] !== 2'(i) || got_data[i] !== tbl[i]) begin
                n_err++; $display("FAIL full_pix%0d: got addr %0d data %h, required addr %0d data %h", i, got_addr[i], got_data[i], i, tbl[i]);
            end
        end
        for (int i = 0; i < sel_q.size(); i++) begin
            n_cmp++;
            if (sel_q[i] !== 1'(i % 2)) begin
                n_err++; $display("FAIL full_colsel%0d: got %0d, required %0d", i, sel_q[i], i % 2);
            end
        end
        n_cmp++;
        if (start_cyc.size() < 2 || start_cyc[0] != req_cyc + 1 || start_cyc[1] - start_cyc[0] != lat + 2) begin
            n_err++; $display("FAIL full_start_timing: got %0d starts, first at +%0d, required first at +1 and period %0d",
                              start_cyc.size(), start_cyc.size() > 0 ? start_cyc[0] - req_cyc : -1, lat + 2);
        end
        n_cmp++;
        if (fd_cnt != 1 || fd_cyc != last_xfer_cyc + 1) begin
            n_err++; $display("FAIL full_frame_done: got %0d pulses at +%0d, required 1 at +1", fd_cnt, fd_cyc - last_xfer_cyc);
        end
        n_cmp++;
        if ({Overrun, Timeout} !== 2'b00) begin
            n_err++; $display("FAIL full_flags: got %b, required 00", {Overrun, Timeout});
        end
    endtask

    task automatic test_random_frames();
        for (int k = 0; k < 4; k++) begin
            bit only2;
            int base;
            idle_all();
            lat = $urandom_range(1, 8);
            only2 = 1'($urandom_range(0, 1));
            base = only2 ? 2 : 0;
            rnd_ready = 1; ADC = 1;
            if (!only2) begin
                NRE_1 = 0;
                wait_got(2);
                NRE_1 = 1;
                tick();
            end
            NRE_2 = 0;
            wait_got(4 - base);
            tick(3);
            rnd_ready = 0;
            n_cmp++;
            if (got_addr.size() != 4 - base || sent.size() < 4 - base) begin
                n_err++; $display("FAIL rand%0d_count: got %0d transfers, required %0d", k, got_addr.size(), 4 - base);
            end else begin
                for (int i = 0; i < 4 - base; i++) begin
                    n_cmp++;
                    if (got_addr[i] !== 2'(base + i) || got_data[i] !== sent[i]) begin
                        n_err++; $display("FAIL rand%0d_pix%0d: got addr %0d data %h, required addr %0d data %h", k, i, got_addr[i], got_data[i], base + i, sent[i]);
                    end
                end
            end
            n_cmp++;
            if (fd_cnt != 1) begin
                n_err++; $display("FAIL rand%0d_frame_done: got %0d pulses, required 1", k, fd_cnt);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] held;
        idle_all();
        lat = 3; Pix_ready = 1; ADC = 1; NRE_1 = 0;
        for (int t = 0; t < 200 && !(Pix_valid && Pix_addr == 2'd1); t++) tick();
        Pix_ready = 0;
        held = Pix_data;
        n_cmp++;
        if (sent.size() < 2 || held !== sent[1]) begin
            n_err++; $display("FAIL bp_held_data: got %h, required second sample", held);
        end
        repeat (5) begin
            tick();
            n_cmp++;
            if (Pix_valid !== 1'b1 || Pix_addr !== 2'd1 || Pix_data !== held) begin
                n_err++; $display("FAIL bp_stable: got valid %b addr %0d data %h, required 1 1 %h", Pix_valid, Pix_addr, Pix_data, held);
            end
            n_cmp++;
            if (Adc_start !== 1'b0) begin
                n_err++; $display("FAIL bp_no_start: got Adc_start %b, required 0", Adc_start);
            end
        end
        Pix_ready = 1;
        wait_got(2);
        tick(5);
        n_cmp++;
        if (got_addr.size() != 2 || got_addr[0] !== 2'd0 || got_addr[1] !== 2'd1 || got_data[0] !== sent[0] || got_data[1] !== sent[1]) begin
            n_err++; $display("FAIL bp_order: got %0d transfers, required addr 0,1 in sample order", got_addr.size());
        end
        n_cmp++;
        if (start_cyc.size() != 2) begin
            n_err++; $display("FAIL bp_starts: got %0d starts, required 2", start_cyc.size());
        end
    endtask

    task automatic test_priority();
        idle_all();
        lat = 2; Pix_ready = 1; ADC = 1; NRE_1 = 0; NRE_2 = 0;
        wait_got(2);
        tick(30);
        n_cmp++;
        if (got_addr.size() != 2 || got_addr[0] !== 2'd0 || got_addr[1] !== 2'd1) begin
            n_err++; $display("FAIL prio_addrs: got %0d transfers, required addr 0,1 once", got_addr.size());
        end
        n_cmp++;
        if (start_cyc.size() != 2 || fd_cnt != 0) begin
            n_err++; $display("FAIL prio_hold: got %0d starts %0d frame_done, required 2 and 0", start_cyc.size(), fd_cnt);
        end
    endtask

    task automatic test_abort();
        idle_all();
        lat = 6; Pix_ready = 1; ADC = 1; NRE_1 = 0;
        for (int t = 0; t < 200 && start_cyc.size() < 2; t++) tick();
        tick(2);
        NRE_1 = 1;
        tick();
        n_cmp++;
        if (Overrun !== 1'b1 || Pix_valid !== 1'b0) begin
            n_err++; $display("FAIL abort_flag: got Overrun %b valid %b, required 1 0", Overrun, Pix_valid);
        end
        for (int t = 0; t < 200 && busy; t++) tick();
        tick(2);
        NRE_2 = 0;
        wait_got(3);
        tick(4);
        n_cmp++;
        if (got_addr.size() != 3 || sent.size() < 4) begin
            n_err++; $display("FAIL abort_count: got %0d transfers, required 3", got_addr.size());
        end else begin
            n_cmp++;
            if (got_addr[0] !== 2'd0 || got_addr[1] !== 2'd2 || got_addr[2] !== 2'd3 ||
                got_data[0] !== sent[0] || got_data[1] !== sent[2] || got_data[2] !== sent[3]) begin
                n_err++; $display("FAIL abort_pixels: got addrs %0d,%0d,%0d, required 0,2,3 with matching samples", got_addr[0], got_addr[1], got_addr[2]);
            end
        end
        n_cmp++;
        if (fd_cnt != 0 || Overrun !== 1'b1) begin
            n_err++; $display("FAIL abort_frame: got %0d frame_done Overrun %b, required 0 and 1", fd_cnt, Overrun);
        end
    endtask

    task automatic test_timeout();
        int s, hit;
        idle_all();
        n_cmp++;
        if (Overrun !== 1'b1) begin
            n_err++; $display("FAIL overrun_sticky: got %b, required 1", Overrun);
        end
        adc_en = 0; Pix_ready = 1; ADC = 1; NRE_1 = 0;
        tick();
        n_cmp++;
        if (Overrun !== 1'b0) begin
            n_err++; $display("FAIL overrun_clear: got %b, required 0", Overrun);
        end
        for (int t = 0; t < 10 && start_cyc.size() < 1; t++) tick();
        s = (start_cyc.size() > 0) ? start_cyc[0] : cyc;
        hit = -1;
        for (int t = 0; t < 200 && hit < 0; t++) begin
            if (Timeout) hit = cyc;
            else tick();
        end
        n_cmp++;
        if (hit != s + CONV_TIMEOUT + 1) begin
            n_err++; $display("FAIL timeout_cycle: got Timeout at +%0d, required +%0d", hit - s, CONV_TIMEOUT + 1);
        end
        tick(10);
        n_cmp++;
        if (start_cyc.size() != 1 || Pix_valid !== 1'b0 || got_addr.size() != 0) begin
            n_err++; $display("FAIL timeout_row_wait: got %0d starts valid %b, required 1 start and no pixel", start_cyc.size(), Pix_valid);
        end
        NRE_1 = 1;
        tick(2);
        adc_en = 1; NRE_1 = 0;
        tick();
        n_cmp++;
        if (Timeout !== 1'b0) begin
            n_err++; $display("FAIL timeout_clear: got %b, required 0", Timeout);
        end
        wait_got(2);
        n_cmp++;
        if (got_addr.size() != 2) begin
            n_err++; $display("FAIL timeout_recover: got %0d transfers, required 2", got_addr.size());
        end
    endtask

    task automatic test_async_reset();
        idle_all();
        lat = 3; Pix_ready = 0; ADC = 1; NRE_1 = 0;
        for (int t = 0; t < 200 && !Pix_valid; t++) tick();
        n_cmp++;
        if (Pix_valid !== 1'b1) begin
            n_err++; $display("FAIL arst_setup: got valid %b, required 1", Pix_valid);
        end
        #3 Reset = 0;
        #1;
        n_cmp++;
        if ({Adc_start, Col_sel, Pix_data, Pix_addr, Pix_valid, Frame_done, Overrun, Timeout} !== '0) begin
            n_err++; $display("FAIL arst_immediate: got valid %b data %h addr %0d, required all 0", Pix_valid, Pix_data, Pix_addr);
        end
        ADC = 0; NRE_1 = 1;
        tick(2);
        start_cyc.delete(); sent.delete(); got_addr.delete(); got_data.delete();
        Reset = 1;
        tick(10);
        n_cmp++;
        if (start_cyc.size() != 0 || Pix_valid !== 1'b0) begin
            n_err++; $display("FAIL arst_idle: got %0d starts valid %b, required 0 0", start_cyc.size(), Pix_valid);
        end
        Pix_ready = 1; ADC = 1; NRE_1 = 0;
        wait_got(2);
        n_cmp++;
        if (got_addr.size() != 2 || sent.size() < 2 || got_addr[0] !== 2'd0 || got_data[0] !== sent[0] || got_data[1] !== sent[1]) begin
            n_err++; $display("FAIL arst_fresh: got %0d transfers, required addr 0,1 with new samples", got_addr.size());
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_random_frames();
        test_backpressure();
        test_priority();
        test_abort();
        test_timeout();
        test_async_reset();
        idle_all();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
